word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 119 +++++++++++
 tb/tb_word_serializer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// Parallel-to-serial converter with per-word shift order and downstream
// back-pressure; emits a one-cycle done pulse after the last bit is accepted.
module word_serializer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             msb_first,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    sreg_d  = data_in;
                    mode_d  = msb_first;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_ready) begin
                    sreg_d = mode_q ? (sreg_q << 1) : (sreg_q >> 1);
                    // Counter saturates on the last bit instead of wrapping.
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered.
        case (state_d)
            SHIFT: begin
                ser_valid_d = 1'b1;
                busy_d      = 1'b1;
                ser_out_d   = mode_d ? sreg_d[WIDTH-1] : sreg_d[0];
            end
            DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                ser_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: table-driven words with a bit
// scoreboard, plus hand-written reset-abort and continuous-load sequences.
module tb_word_serializer;
    localparam int WIDTH = 16;
    localparam int NO_STALL = 99;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             msb_first;
    logic             ser_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    word_serializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .data_in   (data_in),
        .msb_first (msb_first),
        .ser_ready (ser_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // exp_stream holds the expected bits in emission order, first bit in [15].
    typedef struct {
        logic [WIDTH-1:0] data;
        logic             msb;
        int               stall_at;
        int               stall_len;
        logic             hold_load;
        logic [WIDTH-1:0] exp_stream;
        int               exp_done;
    } vec_t;

    vec_t vecs[7];
    logic exp_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it, where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, {31'd0, ser_valid}, 32'd0);
        check({name, "_busy"},  {31'd0, busy},      32'd0);
        check({name, "_done"},  {31'd0, done},      32'd0);
        check({name, "_out"},   {31'd0, ser_out},   32'd0);
    endtask

    task automatic run_word(input vec_t v, input string name);
        int   c;
        int   idx;
        int   stalls;
        logic fin;
        logic stall;
        logic [WIDTH-1:0] s;

        load      = 1'b1;
        data_in   = v.data;
        msb_first = v.msb;
        ser_ready = 1'b1;
        s = v.exp_stream;
        exp_q.delete();
        for (int i = 0; i < WIDTH; i++) exp_q.push_back(s[WIDTH-1-i]);
        tick();
        if (!v.hold_load) load = 1'b0;

        c = 1; idx = 0; stalls = 0; fin = 1'b0;
        while (c <= 60 && !fin) begin
            // Scramble the inputs every cycle: the word in flight must not notice.
            data_in   = WIDTH'($urandom);
            msb_first = ~msb_first;
            if (ser_valid) begin
                stall = (idx == v.stall_at) && (stalls < v.stall_len);
                ser_ready = ~stall;
                check({name, "_busy_shift"}, {31'd0, busy}, 32'd1);
                if (exp_q.size() == 0) begin
                    check({name, "_extra_bit"}, 32'd1, 32'd0);
                    fin = 1'b1;
                end else begin
                    check({name, "_bit"}, {31'd0, ser_out}, {31'd0, exp_q[0]});
                    if (stall) begin
                        stalls++;
                    end else begin
                        void'(exp_q.pop_front());
                        idx++;
                    end
                end
            end else if (done) begin
                check({name, "_done_cycle"}, c, v.exp_done);
                check({name, "_busy_done"}, {31'd0, busy}, 32'd1);
                check({name, "_out_done"},  {31'd0, ser_out}, 32'd0);
                check({name, "_bits_sent"}, idx, WIDTH);
                fin = 1'b1;
            end else begin
                check({name, "_stream_alive"}, {31'd0, busy}, 32'd1);
                fin = 1'b1;
            end
            ser_ready = fin ? 1'b1 : ser_ready;
            tick();
            c++;
        end
        if (!fin) check({name, "_timeout"}, 32'd0, 32'd1);
        check_idle({name, "_after"});
    endtask

    initial begin
        vecs[0] = '{16'h8001, 1'b1, NO_STALL, 0, 1'b0, 16'h8001, 17};
        vecs[1] = '{16'h00F0, 1'b0, NO_STALL, 0, 1'b0, 16'h0F00, 17};
        vecs[2] = '{16'hA5A5, 1'b1, 3,        3, 1'b0, 16'hA5A5, 20};
        vecs[3] = '{16'h1234, 1'b0, NO_STALL, 0, 1'b0, 16'h2C48, 17};
        vecs[4] = '{16'hC3A1, 1'b1, NO_STALL, 0, 1'b1, 16'hC3A1, 17};
        vecs[5] = '{16'h5E17, 1'b0, 0,        2, 1'b0, 16'hE87A, 19};
        vecs[6] = '{16'h0001, 1'b1, 15,       4, 1'b0, 16'h0001, 21};

        reset = 1'b1; load = 1'b0; data_in = '0; msb_first = 1'b0; ser_ready = 1'b0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        load  = 1'b0;
        tick();
        check_idle("idle_no_load");

        // Vector 4 leaves load high through DONE; vector 5 is then loaded on the
        // first IDLE edge, proving the DONE-cycle load was ignored.
        for (int i = 0; i < 7; i++) begin
            run_word(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset one edge after the 7th transfer discards the word silently.
        load = 1'b1; data_in = 16'h1234; msb_first = 1'b1; ser_ready = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("abort");
        for (int i = 0; i < 20; i++) begin
            if (done || ser_valid) check("abort_no_done", {30'd0, done, ser_valid}, 32'd0);
            tick();
        end
        check("abort_quiet", {30'd0, done, ser_valid}, 32'd0);
        run_word('{16'hFFFF, 1'b1, NO_STALL, 0, 1'b0, 16'hFFFF, 17}, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
